cache_port_arbiter: RTL
=======================

Name: cache_port_arbiter

Overview:
- Shares one cache port (operation/addr/data, 4-phase request/valid/evict handshake) between NUM_REQ requesters, e.g. instruction fetch and load/store.
- Round-robin grant; sequences the full 4-phase cycle on the cache side and mirrors it to the granted requester.
- Sits between the CPU-side ports and the cache slave; tri-state bus resolution is done in the surrounding wrapper, so this block uses unidirectional data.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- DATAWIDTH, 8, data width
- ADDRESSWIDTH, 32, address width

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req_request  input  NUM_REQ  per-requester 4-phase request
- req_operation  input  NUM_REQ x inst_t  per-requester operation
- req_addr  input  NUM_REQ*ADDRESSWIDTH  per-requester address
- req_wdata  input  NUM_REQ*DATAWIDTH  per-requester write data
- req_valid  output  NUM_REQ  per-requester completion (one-hot or zero)
- req_evict  output  NUM_REQ  eviction flag returned with valid
- req_rdata  output  DATAWIDTH  read data, meaningful where req_valid set
- c_operation  output  inst_t  operation to cache
- c_addr  output  ADDRESSWIDTH  address to cache
- c_wdata  output  DATAWIDTH  write data to cache
- c_request  output  1  request to cache
- c_valid  input  1  cache valid
- c_evict  input  1  cache evict
- c_rdata  input  DATAWIDTH  cache read data

Behaviour:
- All outputs are registered.
- Reset values: every output 0; c_operation = 0 encoding of inst_t; state IDLE; rr pointer 0.
- IDLE:
  - If any req_request set, grant g = first set index at or after the pointer (wrapping).
  - Latch operation/addr/wdata of g into the c_* registers; go to ISSUE.
  - c_request rises in the cycle after req_request is sampled (1-cycle latency).
- ISSUE: c_request=1. On c_valid=1, capture c_rdata into req_rdata and c_evict into req_evict[g]; set req_valid[g]=1; go to HOLD.
- HOLD: req_valid[g] held. When req_request[g]=0, drop c_request; go to DRAIN.
- DRAIN: c_request=0. When c_valid=0, clear req_valid[g] and req_evict[g]; pointer = (g+1) mod NUM_REQ; go to IDLE.
- c_operation, c_addr and c_wdata are stable from ISSUE through DRAIN. Requester inputs are ignored after the latch.
- Non-granted requests stay pending; they are never dropped or reordered.
- Requester deasserting request during ISSUE (protocol violation): transaction completes normally, valid is still returned. Requester must observe valid=1 before it may drop request.
- Simultaneous requests: round-robin only. Pointer advances past g only when a transaction completes.
- Back-to-back grants: at least 1 IDLE cycle between transactions. No grant is evaluated in ISSUE, HOLD or DRAIN.
- Reset mid-transaction: next cycle all outputs 0, pointer 0, state IDLE. The in-flight transaction is abandoned; the cache shares the reset.

Optional Feature:
- Macro: CACHE_ARB_STATS_EN.
- Defined: adds output grant_count, NUM_REQ*16 bits, one 16-bit saturating counter per requester.
  - Counter increments on entry to ISSUE for the granted requester.
  - Holds at 0xFFFF when saturated.
  - Cleared by reset.
- Undefined: port and counters absent; behaviour otherwise identical.

Decomposition:
- cachepkg additions:
  - arb_state_t enum {IDLE, ISSUE, HOLD, DRAIN}
  - ARB_CNT_WIDTH = 16
  - ARB_MAX_REQ = 8
- One sub-module: cache_rr_picker. Combinational; inputs request vector and pointer; outputs grant index and any-flag.

Test Plan:
- req_request[0]=1, READ, addr 0x1000; cache returns valid after 3 cycles with rdata 0xA5 -> c_request high 1 cycle after request; c_addr=0x1000; req_valid[0]=1 with req_rdata=0xA5; req_valid[0] falls only after c_valid falls.
- req0 and req1 both asserted after reset, each re-raising request after its valid drops -> grant order 0,1,0,1; never two consecutive grants to the same requester.
- req1 asserts while req0 is in ISSUE with addr 0x20 -> c_addr stays 0x20 until DRAIN completes; req1 is granted in the next IDLE.
- Cache asserts c_evict=1 with c_valid on a WRITE from req1 -> req_evict[1]=1 for exactly the cycles req_valid[1]=1; req_evict[0] stays 0.
- reset=1 during HOLD -> next cycle all outputs 0; req0 then receives the first grant.
- With CACHE_ARB_STATS_EN: 3 transactions from req0 -> grant_count[15:0]=3. Preload near saturation and run 2 more transactions -> holds at 0xFFFF.

Source files
------------

// File: rtl/cache_port_arbiter_pkg.sv
// Shared types and constants for the cache port arbiter.
package cache_port_arbiter_pkg;

  // Cache operation encoding; the zero encoding is the idle/reset value.
  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_FLUSH = 2'd2,
    OP_NOP   = 2'd3
  } inst_t;

  // Arbiter sequencing of one 4-phase cache transaction.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  localparam int ARB_CNT_WIDTH = 16;
  localparam int ARB_MAX_REQ   = 8;

endpackage

// File: rtl/cache_rr_picker.sv
// Combinational round-robin picker: returns the first requesting index at or
// after the pointer, wrapping, plus a flag saying whether anyone requests.
module cache_rr_picker
  import cache_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_request,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_grant,
  output logic               o_any
);

  int w_dist;
  int w_best;

  // Pick the requester with the smallest wrapped distance from the pointer.
  always_comb begin
    o_any   = 1'b0;
    o_grant = '0;
    w_dist  = 0;
    w_best  = NUM_REQ;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (i_request[k]) begin
        w_dist = (k + NUM_REQ - int'(i_ptr)) % NUM_REQ;
        if (w_dist < w_best) begin
          w_best  = w_dist;
          o_grant = IDX_W'(k);
          o_any   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one 4-phase cache port between NUM_REQ
// requesters. The granted requester's operation/addr/wdata are latched when
// the grant is made and held until the handshake fully drains.
// Optional: define CACHE_ARB_STATS_EN to add per-requester 16-bit saturating
// grant counters on the grant_count output.
module cache_port_arbiter
  import cache_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int DATAWIDTH    = 8,
  parameter int ADDRESSWIDTH = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_request,
  input  inst_t [NUM_REQ-1:0]            req_operation,
  input  logic [NUM_REQ*ADDRESSWIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_evict,
  output logic [DATAWIDTH-1:0]           req_rdata,
  output inst_t                          c_operation,
  output logic [ADDRESSWIDTH-1:0]        c_addr,
  output logic [DATAWIDTH-1:0]           c_wdata,
  output logic                           c_request,
  input  logic                           c_valid,
  input  logic                           c_evict,
  input  logic [DATAWIDTH-1:0]           c_rdata
`ifdef CACHE_ARB_STATS_EN
  ,
  output logic [NUM_REQ*ARB_CNT_WIDTH-1:0] grant_count
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t              r_state;
  logic [IDX_W-1:0]        r_ptr;
  logic [IDX_W-1:0]        r_g;
  logic [IDX_W-1:0]        w_grant;
  logic                    w_any;
  logic [IDX_W-1:0]        w_ptr_next;
  inst_t                   w_sel_op;
  logic [ADDRESSWIDTH-1:0] w_sel_addr;
  logic [DATAWIDTH-1:0]    w_sel_wdata;

  cache_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_request (req_request),
    .i_ptr     (r_ptr),
    .o_grant   (w_grant),
    .o_any     (w_any)
  );

  assign w_ptr_next = (r_g == IDX_W'(NUM_REQ - 1)) ? '0 : r_g + 1'b1;

  // Route the candidate requester's command fields toward the latch.
  always_comb begin
    w_sel_op    = OP_READ;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant == IDX_W'(k)) begin
        w_sel_op    = req_operation[k];
        w_sel_addr  = req_addr[k*ADDRESSWIDTH +: ADDRESSWIDTH];
        w_sel_wdata = req_wdata[k*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  // Transaction sequencer; every output is a register written here.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_g         <= '0;
      c_request   <= 1'b0;
      c_operation <= OP_READ;
      c_addr      <= '0;
      c_wdata     <= '0;
      req_valid   <= '0;
      req_evict   <= '0;
      req_rdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_g         <= w_grant;
            c_operation <= w_sel_op;
            c_addr      <= w_sel_addr;
            c_wdata     <= w_sel_wdata;
            c_request   <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (c_valid) begin
            req_rdata      <= c_rdata;
            req_evict[r_g] <= c_evict;
            req_valid[r_g] <= 1'b1;
            r_state        <= HOLD;
          end
        end
        HOLD: begin
          if (!req_request[r_g]) begin
            c_request <= 1'b0;
            r_state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (!c_valid) begin
            req_valid <= '0;
            req_evict <= '0;
            r_ptr     <= w_ptr_next;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_ARB_STATS_EN
  logic [ARB_CNT_WIDTH-1:0] r_cnt [NUM_REQ];

  function automatic logic [ARB_CNT_WIDTH-1:0] sat_inc(input logic [ARB_CNT_WIDTH-1:0] v);
    return (v == {ARB_CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Count grants per requester, saturating at all-ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NUM_REQ; k++) r_cnt[k] <= '0;
    end else if (r_state == IDLE && w_any) begin
      r_cnt[w_grant] <= sat_inc(r_cnt[w_grant]);
    end
  end

  for (genvar gk = 0; gk < NUM_REQ; gk++) begin : g_cnt_out
    assign grant_count[gk*ARB_CNT_WIDTH +: ARB_CNT_WIDTH] = r_cnt[gk];
  end
`endif

endmodule
